// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] PC_INCR           = 32'd4;

    // Reduce a byte address into the instruction-memory window.
    function automatic logic [31:0] pc_wrap(input logic [31:0] addr,
                                            input logic [31:0] span);
        return addr % span;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage control, memory and IF/ID signals.
// Latency: n/a (wiring only).
// Backpressure: stall holds the stage; redirect overrides stall.
interface fetch_stage_if;

    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    // Fetch stage side.
    modport master (
        input  stall, flush, redirect, redirect_pc, imem_instr,
        output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4,
               halted, misalign_err, fetch_count
    );

    // Pipeline / memory side.
    modport slave (
        output stall, flush, redirect, redirect_pc, imem_instr,
        input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4,
               halted, misalign_err, fetch_count
    );

endinterface

// File: rtl/ifid_register.sv
// IF/ID pipeline register: valid, instruction, pc and pc+4.
// Latency: 1 cycle from load to outputs.
// Backpressure: holds when neither load nor bubble; load wins over bubble.
module ifid_register
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus4_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    // Load a new entry, squash only the valid bit, or hold everything.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (load) begin
            valid_d    = 1'b1;
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus4_d = pc_plus4_in;
        end else if (bubble) begin
            valid_d    = 1'b0;
        end
    end

    // Register state with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_WORD;
            pc_q       <= 32'd0;
            pc_plus4_q <= 32'd0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, samples the memory word into IF/ID.
// Latency: 1 cycle PC -> IF/ID; one BOOT cycle after reset before first capture.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall; halt word freezes fetch.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    // Byte span of instruction memory; all PC arithmetic wraps inside it.
    localparam logic [31:0] PC_SPAN = 32'(4 * IMEM_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  count_q, count_d;
    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  pc_inc;
    logic [31:0]  redirect_target;
    logic         redirect_misaligned;

    assign pc_inc              = pc_wrap(pc_q + PC_INCR, PC_SPAN);
    assign redirect_target     = pc_wrap({bus.redirect_pc[31:2], 2'b00}, PC_SPAN);
    assign redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);

    // Next state, PC and IF/ID controls, in redirect > stall > flush > capture order.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        misalign_d  = misalign_q;
        count_d     = count_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (state_q)
            BOOT: begin
                // Memory output settles for one cycle; nothing is captured.
                state_d = RUN;
            end
            RUN: begin
                if (bus.redirect) begin
                    pc_d        = redirect_target;
                    ifid_bubble = 1'b1;
                    if (redirect_misaligned) misalign_d = 1'b1;
                end else if (bus.stall) begin
                    ifid_bubble = bus.flush;
                end else if (bus.flush) begin
                    ifid_bubble = 1'b1;
                    pc_d        = pc_inc;
                end else begin
                    ifid_load = 1'b1;
                    if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
                    // The halt word is still delivered, but the PC stays on it.
                    if (bus.imem_instr == HALT_WORD) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            HALTED: begin
                if (bus.redirect) begin
                    // Halt was on a wrong path: resume at the target.
                    state_d     = RUN;
                    pc_d        = redirect_target;
                    ifid_bubble = 1'b1;
                    if (redirect_misaligned) misalign_d = 1'b1;
                end else if (!bus.stall) begin
                    ifid_bubble = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC, sticky error and delivered-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    ifid_register u_ifid (
        .clk         (clk),
        .reset       (reset),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .instr_in    (bus.imem_instr),
        .pc_in       (pc_q),
        .pc_plus4_in (pc_inc),
        .valid       (bus.ifid_valid),
        .instr       (bus.ifid_instr),
        .pc          (bus.ifid_pc),
        .pc_plus4    (bus.ifid_pc_plus4)
    );

    assign bus.imem_addr    = pc_q;
    assign bus.halted       = (state_q == HALTED);
    assign bus.misalign_err = misalign_q;
    assign bus.fetch_count  = count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the InstructionMemory block.
- Owns the program counter and drives the memory address.
- Samples the memory's combinational instruction word into the IF/ID pipeline register, together with its PC and PC+4.
- Honours stall and flush from the hazard unit and redirects from branch/jump resolution; halts on a dedicated halt word.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 1024, instruction-memory depth in 32-bit words; PC wraps modulo 4*IMEM_DEPTH bytes.
- HALT_WORD, 32'hFC00_0000, instruction encoding that stops sequential fetch.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  squash IF/ID (load a bubble)
- redirect  in  1  load redirect_pc into PC
- redirect_pc  in  32  branch/jump target byte address
- imem_addr  out  32  byte address to InstructionMemory
- imem_instr  in  32  instruction word returned by InstructionMemory
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  32  IF/ID instruction
- ifid_pc  out  32  PC of ifid_instr
- ifid_pc_plus4  out  32  ifid_pc + 4, wrapped
- halted  out  1  fetch is halted
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0
- fetch_count  out  32  valid instructions delivered, saturating

Behaviour:
- Reset (asynchronous, any time, including mid-redirect or mid-stall) forces:
  - state=BOOT, pc=RESET_PC
  - ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus4=0
  - halted=0, misalign_err=0, fetch_count=0
- imem_addr = pc register directly, with no logic after the flop.
- Memory read is treated as combinational within the cycle; imem_instr is sampled at the next rising edge. Fetch latency: PC to ifid_* is 1 cycle.
- States are BOOT, RUN and HALTED.
- BOOT (exactly one cycle after reset release):
  - pc held, ifid_valid=0, no capture; this lets the memory output settle.
  - Next state is always RUN; inputs are ignored.
- RUN, per edge, in priority order:
  1. redirect: pc <= {redirect_pc[31:2],2'b00} mod 4*IMEM_DEPTH; ifid_valid <= 0, since the current word is wrong-path. stall is ignored. If redirect_pc[1:0] != 0, set misalign_err.
  2. stall (no redirect): pc and all ifid_* hold. If flush is also asserted, ifid_valid <= 0 and the other ifid_* fields hold.
  3. flush (no stall, no redirect): ifid_valid <= 0; pc <= pc+4, wrapped.
  4. Otherwise, capture: ifid_instr <= imem_instr, ifid_pc <= pc, ifid_pc_plus4 <= pc+4 (wrapped), ifid_valid <= 1, pc <= pc+4 (wrapped), fetch_count += 1 (saturating at 32'hFFFF_FFFF).
     - If imem_instr == HALT_WORD: the halt word is still delivered with valid=1, pc is NOT advanced, and state <= HALTED.
- HALTED:
  - halted=1, pc frozen.
  - ifid_valid <= 0 on the next edge unless stall is asserted, in which case IF/ID holds.
  - redirect returns the block to RUN with the pc load described in RUN step 1 and halted <= 0. This is wrong-path halt recovery.
  - stall and flush have no other effect.
- PC arithmetic: all PC additions are modulo 4*IMEM_DEPTH, so pc = 4*IMEM_DEPTH-4 wraps to 0. The upper bits of imem_addr are always 0.
- misalign_err is sticky until reset.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (BOOT, RUN, HALTED)
  - HALT_WORD default
  - NOP_WORD (32'h0)
  - PC increment constant 4
- One natural sub-module: ifid_register, holding the valid/instr/pc/pc_plus4 flops with load, hold and bubble controls.

Test Plan:
- Reset release with memory words 0x11,0x22,0x33 at words 0-2 -> imem_addr=0 for 2 cycles, ifid_valid=0 in BOOT; ifid_instr=0x11/pc=0 one cycle later, then 0x22/pc=4, then 0x33/pc=8; fetch_count=3.
- stall asserted 2 cycles while ifid holds pc=4 -> imem_addr stays 8, ifid_pc stays 4, fetch_count unchanged; on release the next capture has pc=8.
- redirect=1, redirect_pc=0x40, stall=1 in the same cycle -> ifid_valid=0, imem_addr=0x40; next cycle ifid_pc=0x40. Repeat with redirect_pc=0x42 -> imem_addr=0x40, misalign_err=1 and stays set.
- Halt: HALT_WORD at 0x0C -> delivered with ifid_pc=0x0C and valid=1, then halted=1, imem_addr frozen at 0x0C, ifid_valid=0. A later redirect to 0x20 -> halted=0 and fetch resumes at 0x20.
- Wrap: redirect to 0xFFC with IMEM_DEPTH=1024 -> ifid_pc_plus4=0, imem_addr=0 next cycle.
- Reset asserted mid-stream while a redirect is pending -> all outputs return to reset values immediately, asynchronously; the BOOT sequence repeats.
